// File: rtl/muldiv_unit.sv
// Iterative unsigned 32x32 multiply / 32/32 divide unit. The result is returned
// as two register-file writes: high word or remainder, then low word or quotient.
module muldiv_unit #(
    parameter logic [5:0] HI_ADDR = 6'd61,
    parameter logic [5:0] LO_ADDR = 6'd62,
    parameter logic [1:0] MULT    = 2'b01,
    parameter logic [1:0] DIV     = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        done,
    output logic [5:0]  wbAddr,
    output logic [31:0] wbData,
    output logic        wbEnable
);

    typedef enum logic [1:0] {IDLE, CALC, WB_HI, WB_LO} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic [31:0] operand_q, operand_d;    // multiplicand or divisor
    logic [63:0] acc_q, acc_d;            // product, or quotient/dividend in [31:0]
    logic [32:0] rem_q, rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wb_en_q, wb_en_d;
    logic [5:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic        fits;

    // NOTE: every signal gets a default at the top so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wb_en_d   = 1'b0;
        wb_addr_d = 6'd0;
        wb_data_d = 32'd0;
        add_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, operand_q} : 33'd0);
        shifted   = {rem_q[31:0], acc_q[31]};
        fits      = (shifted >= {1'b0, operand_q});

        case (state_q)
            IDLE: begin
                if (start && (op == MULT || op == DIV)) begin
                    state_d   = CALC;
                    cnt_d     = 6'd0;
                    busy_d    = 1'b1;
                    is_div_d  = (op == DIV);
                    operand_d = (op == DIV) ? opB : opA;
                    acc_d     = (op == DIV) ? {32'd0, opA} : {32'd0, opB};
                    rem_d     = 33'd0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div_q) begin
                    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
                    rem_d = fits ? (shifted - {1'b0, operand_q}) : shifted;
                    acc_d = {acc_q[63:32], acc_q[30:0], fits};
                end else begin
                    acc_d = {add_sum, acc_q[31:1]};
                end
                if (cnt_q == 6'd31) begin
                    state_d   = WB_HI;
                    wb_en_d   = 1'b1;
                    wb_addr_d = HI_ADDR;
                    wb_data_d = is_div_q ? rem_d[31:0] : acc_d[63:32];
                end
            end
            WB_HI: begin
                state_d   = WB_LO;
                wb_en_d   = 1'b1;
                wb_addr_d = LO_ADDR;
                wb_data_d = acc_q[31:0];
                done_d    = 1'b1;
            end
            WB_LO: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: every register, including the datapath, is cleared by reset so an abandoned
    // operation can never leak a write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            is_div_q  <= 1'b0;
            operand_q <= 32'd0;
            acc_q     <= 64'd0;
            rem_q     <= 33'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= 6'd0;
            wb_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wbEnable = wb_en_q;
    assign wbAddr   = wb_addr_q;
    assign wbData   = wb_data_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit for the processor datapath. It consumes the two operands read from the register file (`inReg1Data`, `inReg2Data`), computes a 64-bit product or a quotient/remainder pair over 32 cycles, and feeds the result back to the register file's single write port as two consecutive writes to the dedicated registers 61 and 62. While it runs, it tells the control unit to hold off through a busy/done handshake.

## Interface
- `HI_ADDR`, default 61: destination register for the product high word or the remainder.
- `LO_ADDR`, default 62: destination register for the product low word or the quotient.
- `MULT`, default 2'b01: op encoding for multiply.
- `DIV`, default 2'b10: op encoding for divide.
- One clock; reset is asynchronous and active-low.
- `clk`  input  1  clock; all state updates on the posedge.
- `reset`  input  1  asynchronous, active-low reset. 0 clears all state immediately.
- `start`  input  1  request to begin an operation; sampled on the posedge.
- `op`  input  2  operation select; sampled with `start`.
- `opA`  input  32  multiplicand or dividend; sampled with `start`.
- `opB`  input  32  multiplier or divisor; sampled with `start`.
- `busy`  output  1  high from the cycle after an accepted start through the last write-back cycle.
- `done`  output  1  one-cycle pulse during the final write-back cycle.
- `wbAddr`  output  6  register-file write address.
- `wbData`  output  32  register-file write data.
- `wbEnable`  output  1  register-file write enable; held for the whole cycle.

## Operation
- States:
  - IDLE: waits for a start.
  - CALC: computes for exactly 32 cycles, tracked by a 6-bit counter.
  - WB_HI: writes the high word or remainder.
  - WB_LO: writes the low word or quotient.
- Accept rule: a start is accepted only when the block is in IDLE, `start` = 1, and `op` is `MULT` or `DIV`.
  - `op` = 2'b00 or 2'b11 is ignored; the block stays in IDLE.
  - `start` outside IDLE is ignored. There is no queueing.
- On acceptance, `opA`, `opB` and `op` are latched. Later changes to the inputs have no effect on the running operation.
- MULT: unsigned shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
  - Result: `HI_ADDR` ← product[63:32], `LO_ADDR` ← product[31:0].
- DIV: unsigned restoring division, one quotient bit per cycle, using a 33-bit partial remainder.
  - Result: `HI_ADDR` ← remainder, `LO_ADDR` ← quotient.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = `opA`. No trap is raised.
- Write-back outputs:
  - WB_HI: `wbEnable` = 1, `wbAddr` = `HI_ADDR`, `wbData` = high word or remainder.
  - WB_LO: `wbEnable` = 1, `wbAddr` = `LO_ADDR`, `wbData` = low word or quotient, `done` = 1.
  - All other states: `wbEnable` = 0, `wbAddr` = 0, `wbData` = 0.
- Reset values: state = IDLE; `busy`, `done`, `wbEnable` = 0; `wbAddr` = 0; `wbData` = 0; counter and accumulators = 0.
- Reset asserted mid-operation: the operation is abandoned immediately (asynchronous). No partial write-back is ever issued.

## Timing
- Start accepted on posedge T0.
- Cycles T0+1 … T0+32: CALC, `busy` = 1.
- Cycle T0+33: WB_HI.
- Cycle T0+34: WB_LO with `done` = 1; `busy` stays 1 in this cycle.
- Cycle T0+35: back in IDLE with `busy` = 0. A new start presented in this cycle is accepted on its posedge. Back-to-back throughput is one operation per 35 cycles.
- The register file captures write-back data on the negedge. `wbAddr`, `wbData` and `wbEnable` are registered outputs, stable from posedge to posedge.
- The block has no write-port arbitration. Control must not issue its own register write while `busy` = 1 and `wbEnable` = 1.

## Test plan
- MULT, `opA` = 7, `opB` = 6 → write 61 ← 0x00000000 at T0+33, write 62 ← 0x0000002A at T0+34; `done` pulses for exactly 1 cycle.
- MULT, 0xFFFFFFFF × 0xFFFFFFFF → 61 ← 0xFFFFFFFE, 62 ← 0x00000001.
- DIV, 100 / 7 → 61 ← 2, 62 ← 14. Also 0x80000000 / 1 → 61 ← 0, 62 ← 0x80000000.
- DIV, 5 / 0 → 61 ← 5, 62 ← 0xFFFFFFFF; exactly 2 writes.
- Start MULT 3 × 4, then pulse `start` with DIV and new operands at T0+10 → second request ignored; results 61 ← 0, 62 ← 12; `op` = 00 with `start` in IDLE leaves `busy` = 0.
- Assert `reset` low at T0+10 during a DIV → `busy`, `wbEnable`, `done` drop to 0 immediately with no clock edge; no writes occur; after release, a fresh MULT 2 × 3 yields 62 ← 6.
